// File: rtl/elevator_pkg.sv
// Shared sizing, FSM encodings and direction constants for the elevator
// floor request scheduler.
package elevator_pkg;

  localparam int NUM_FLOORS  = 4;
  localparam int FLOOR_W     = 2;
  localparam int REQ_TIMEOUT = 16;
  localparam int CNT_W       = $clog2(REQ_TIMEOUT + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_MOVE    = 2'd2;
  localparam logic [1:0] S_SERVICE = 2'd3;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/floor_request_scheduler_select.sv
// Combinational SCAN picker: nearest pending floor ahead in the sweep
// direction, otherwise the nearest one behind with the sweep reversed.
module floor_select
  import elevator_pkg::*;
(
  input  logic [NUM_FLOORS-1:0] pending_i,
  input  logic [FLOOR_W-1:0]    current_floor_i,
  input  logic                  dir_up_i,
  output logic                  valid_o,
  output logic [FLOOR_W-1:0]    target_o,
  output logic                  new_dir_o
);

  logic               up_found;
  logic               dn_found;
  logic [FLOOR_W-1:0] up_floor;
  logic [FLOOR_W-1:0] dn_floor;

  always_comb begin
    up_found = 1'b0;
    dn_found = 1'b0;
    up_floor = '0;
    dn_floor = '0;
    // Descending scan leaves the lowest floor above; ascending scan the highest below.
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending_i[i] && (i > int'(current_floor_i))) begin
        up_found = 1'b1;
        up_floor = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_i[i] && (i < int'(current_floor_i))) begin
        dn_found = 1'b1;
        dn_floor = FLOOR_W'(i);
      end
    end
  end

  always_comb begin
    valid_o   = up_found | dn_found;
    target_o  = '0;
    new_dir_o = dir_up_i;
    if (dir_up_i == DIR_UP) begin
      if (up_found) begin
        target_o  = up_floor;
        new_dir_o = DIR_UP;
      end else if (dn_found) begin
        target_o  = dn_floor;
        new_dir_o = DIR_DN;
      end
    end else begin
      if (dn_found) begin
        target_o  = dn_floor;
        new_dir_o = DIR_DN;
      end else if (up_found) begin
        target_o  = up_floor;
        new_dir_o = DIR_UP;
      end
    end
  end

endmodule

// File: rtl/floor_request_scheduler.sv
// Latches floor calls, picks the next target with a SCAN sweep and holds an
// up/down request to the elevator controller until it starts moving.
module floor_request_scheduler
  import elevator_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  move_up,
  input  logic                  move_down,
  input  logic                  door_open,
  input  logic                  emergency_stop,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic                  up_request,
  output logic                  down_request,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  busy,
  output logic [1:0]            sched_state
);

  // Handshake: up/down_request (valid) is held with a stable target_floor until
  // move_up|move_down (ready) is seen, or until REQ_TIMEOUT cycles elapse.

  logic [1:0]            state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [FLOOR_W-1:0]    target_q, target_d;
  logic                  up_q, up_d;
  logic                  dn_q, dn_d;
  logic                  dir_q, dir_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q;
  logic [NUM_FLOORS-1:0] clr;
  logic                  sel_valid;
  logic [FLOOR_W-1:0]    sel_target;
  logic                  sel_dir;

  floor_select u_select (
    .pending_i       (pending_q),
    .current_floor_i (current_floor),
    .dir_up_i        (dir_q),
    .valid_o         (sel_valid),
    .target_o        (sel_target),
    .new_dir_o       (sel_dir)
  );

  // A call at the floor the car is idling at, or where the door is open, is already served.
  assign clr       = (door_open || (state_q == S_IDLE)) ? (NUM_FLOORS'(1) << current_floor) : '0;
  assign pending_d = (pending_q | call_req) & ~clr;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    up_d     = up_q;
    dn_d     = dn_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    if (emergency_stop && (state_q != S_IDLE)) begin
      up_d    = 1'b0;
      dn_d    = 1'b0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sel_valid && !emergency_stop) begin
            target_d = sel_target;
            dir_d    = sel_dir;
            up_d     = (sel_target > current_floor);
            dn_d     = (sel_target < current_floor);
            cnt_d    = '0;
            state_d  = S_REQ;
          end
        end
        S_REQ: begin
          if (move_up || move_down) begin
            up_d    = 1'b0;
            dn_d    = 1'b0;
            state_d = S_MOVE;
          end else if (cnt_q == CNT_W'(REQ_TIMEOUT - 1)) begin
            up_d    = 1'b0;
            dn_d    = 1'b0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_MOVE: begin
          if ((current_floor == target_q) && door_open) state_d = S_SERVICE;
        end
        default: begin
          if (!door_open) state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      target_q  <= '0;
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
      dir_q     <= DIR_UP;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      target_q  <= target_d;
      up_q      <= up_d;
      dn_q      <= dn_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      busy_q    <= (state_d != S_IDLE);
    end
  end

  assign target_floor = target_q;
  assign up_request   = up_q;
  assign down_request = dn_q;
  assign pending      = pending_q;
  assign dir_up       = dir_q;
  assign busy         = busy_q;
  assign sched_state  = state_q;

endmodule
